// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// start/busy/done framing and an overflow flag for values beyond DIGITS digits.
module bin_to_bcd_seq #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = (IN_WIDTH < 2) ? 1 : $clog2(IN_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] sh;
  logic [IN_WIDTH-1:0] sh_nx;
  logic [BW-1:0]       acc;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       acc_nx;
  logic [CW-1:0]       cnt;
  logic                sticky;
  logic                carry;
  logic                last;

  // One double-dabble step: add 3 to digits >= 5, then shift {acc, sh} left.
  always_comb begin
    adj = acc;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
    carry  = adj[BW-1];
    acc_nx = {adj[BW-2:0], sh[IN_WIDTH-1]};
    sh_nx  = sh << 1;
    last   = (cnt == CW'(IN_WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      acc      <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh     <= bin_in;
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc    <= acc_nx;
          sh     <= sh_nx;
          sticky <= sticky | carry;
          cnt    <= cnt + CW'(1);
          if (last) begin
            // Publish result together with the done pulse.
            bcd_out  <= acc_nx;
            overflow <= sticky | carry;
            done     <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default 3-digit instance plus a
// 2-digit instance for overflow, checked against an arithmetic reference.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [7:0]  bin_a, bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
  );

  // Reference: decimal digits of (v mod 10^d), overflow when v >= 10^d.
  function automatic void ref_conv(input int v, input int d,
                                   output logic [11:0] bcd, output logic ovf);
    int p = 1;
    int m;
    for (int k = 0; k < d; k++) p = p * 10;
    ovf = (v > p - 1);
    m   = v % p;
    bcd = '0;
    for (int k = 0; k < d; k++) begin
      bcd[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  // Caller has start/bin set before a posedge; that edge is the accepting edge.
  // Returns at the negedge where done is seen (or after the cycle budget).
  task automatic run(input bit sel, input bit hold, input logic [7:0] hold_val,
                     output logic [11:0] bcd, output logic ovf,
                     output int lat, output int bcnt, output bit both);
    logic b, d;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      if (sel) bin_b = hold_val; else bin_a = hold_val;
    end else begin
      start_a = 1'b0; start_b = 1'b0;
    end
    lat = -1; bcnt = 0; both = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      b = sel ? busy_b : busy_a;
      d = sel ? done_b : done_a;
      if (b && d) both = 1'b1;
      if (b) bcnt++;
      if (d) begin lat = i - 1; break; end
      @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0;
    bcd = sel ? {4'h0, bcd_b} : bcd_a;
    ovf = sel ? ovf_b : ovf_a;
  endtask

  task automatic conv(input bit sel, input logic [7:0] v,
                      output logic [11:0] bcd, output logic ovf,
                      output int lat, output int bcnt, output bit both);
    @(negedge clk);
    if (sel) begin start_b = 1'b1; bin_b = v; end
    else     begin start_a = 1'b1; bin_a = v; end
    run(sel, 1'b0, 8'h00, bcd, ovf, lat, bcnt, both);
  endtask

  task automatic check_conv(input string name, input bit sel, input logic [7:0] v);
    logic [11:0] bcd, exp_bcd;
    logic ovf, exp_ovf;
    int lat, bcnt;
    bit both;
    conv(sel, v, bcd, ovf, lat, bcnt, both);
    ref_conv(int'(v), sel ? 2 : 3, exp_bcd, exp_ovf);
    total++;
    if (bcd !== exp_bcd) $display("FAIL %s bcd v=%0d got=%h exp=%h", name, v, bcd, exp_bcd);
    else passed++;
    total++;
    if (ovf !== exp_ovf) $display("FAIL %s ovf v=%0d got=%b exp=%b", name, v, ovf, exp_ovf);
    else passed++;
    total++;
    if (lat !== 8 || bcnt !== 8 || both) $display("FAIL %s timing v=%0d lat=%0d busy=%0d both=%0b exp 8/8/0",
                                                  name, v, lat, bcnt, both);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy_a, done_a, bcd_a, ovf_a} !== 15'd0)
      $display("FAIL reset_a got busy=%b done=%b bcd=%h ovf=%b exp all 0", busy_a, done_a, bcd_a, ovf_a);
    else passed++;
    total++;
    if ({busy_b, done_b, bcd_b, ovf_b} !== 11'd0)
      $display("FAIL reset_b got busy=%b done=%b bcd=%h ovf=%b exp all 0", busy_b, done_b, bcd_b, ovf_b);
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0)
      $display("FAIL idle_after_reset busy=%b done=%b exp 0 0", busy_a, done_a);
    else passed++;
  endtask

  task automatic test_corners;
    check_conv("zero", 1'b0, 8'd0);
    check_conv("v255", 1'b0, 8'd255);
    check_conv("v99",  1'b0, 8'd99);
    check_conv("v100", 1'b0, 8'd100);
  endtask

  task automatic test_sweep;
    logic [11:0] bcd, exp_bcd;
    logic ovf, exp_ovf;
    int lat, bcnt;
    bit both;
    bit digit_bad;
    for (int v = 0; v < 256; v++) begin
      conv(1'b0, 8'(v), bcd, ovf, lat, bcnt, both);
      ref_conv(v, 3, exp_bcd, exp_ovf);
      total++;
      if (bcd !== exp_bcd || ovf !== exp_ovf || lat !== 8)
        $display("FAIL sweep v=%0d got bcd=%h ovf=%b lat=%0d exp %h %b 8", v, bcd, ovf, lat, exp_bcd, exp_ovf);
      else passed++;
      digit_bad = 1'b0;
      for (int k = 0; k < 3; k++) if (bcd[4*k +: 4] > 4'd9) digit_bad = 1'b1;
      total++;
      if (digit_bad || ovf !== 1'b0) $display("FAIL sweep_digits v=%0d bcd=%h ovf=%b exp digits<=9 ovf=0", v, bcd, ovf);
      else passed++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) check_conv("rand_a", 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 30; i++) check_conv("rand_b", 1'b1, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_digits2;
    check_conv("d2_v200", 1'b1, 8'd200);
    check_conv("d2_v99",  1'b1, 8'd99);
    check_conv("d2_v100", 1'b1, 8'd100);
  endtask

  task automatic test_ignore_start;
    logic [11:0] bcd;
    logic ovf;
    int lat, bcnt;
    bit both, extra;
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd37;
    run(1'b0, 1'b1, 8'd200, bcd, ovf, lat, bcnt, both);
    total++;
    if (bcd !== 12'h037 || ovf !== 1'b0 || lat !== 8 || bcnt !== 8)
      $display("FAIL ignore_start got bcd=%h ovf=%b lat=%0d busy=%0d exp 037 0 8 8", bcd, ovf, lat, bcnt);
    else passed++;
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy_a || done_a) extra = 1'b1;
    end
    total++;
    if (extra || bcd_a !== 12'h037) $display("FAIL ignore_start_idle extra=%b bcd=%h exp 0 037", extra, bcd_a);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [11:0] bcd;
    logic ovf;
    int lat, bcnt;
    bit both;
    conv(1'b0, 8'd12, bcd, ovf, lat, bcnt, both);
    total++;
    if (bcd !== 12'h012 || lat !== 8) $display("FAIL b2b_first got bcd=%h lat=%0d exp 012 8", bcd, lat);
    else passed++;
    start_a = 1'b1; bin_a = 8'd250;
    run(1'b0, 1'b0, 8'h00, bcd, ovf, lat, bcnt, both);
    total++;
    if (bcd !== 12'h250 || ovf !== 1'b0 || lat !== 8 || bcnt !== 8 || both)
      $display("FAIL b2b_second got bcd=%h ovf=%b lat=%0d busy=%0d both=%0b exp 250 0 8 8 0",
               bcd, ovf, lat, bcnt, both);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit seen;
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd255;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy_a !== 1'b1 || bcd_a !== 12'h250) $display("FAIL mid_hold busy=%b bcd=%h exp 1 250", busy_a, bcd_a);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy_a, done_a, bcd_a, ovf_a} !== 15'd0)
      $display("FAIL mid_reset got busy=%b done=%b bcd=%h ovf=%b exp all 0", busy_a, done_a, bcd_a, ovf_a);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy_a || done_a) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL mid_reset_idle got activity=1 exp 0");
    else passed++;
    check_conv("after_reset_v9", 1'b0, 8'd9);
  endtask

  initial begin
    test_reset();
    test_corners();
    test_digits2();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
